// File: rtl/reset_sequencer_if.sv
// Control bus of the three-stage reset sequencer: restart/acknowledge in,
// per-stage releases and status out.
interface reset_sequencer_if;
    logic       iRESTART;
    logic [2:0] iACK;
    logic       oRST_0;
    logic       oRST_1;
    logic       oRST_2;
    logic       oDONE;
    logic       oFAULT;
    logic [1:0] oSTAGE;

    // Requester side: drives restart and stage acknowledges, observes status.
    modport master (
        output iRESTART, iACK,
        input  oRST_0, oRST_1, oRST_2, oDONE, oFAULT, oSTAGE
    );

    // Sequencer side.
    modport slave (
        input  iRESTART, iACK,
        output oRST_0, oRST_1, oRST_2, oDONE, oFAULT, oSTAGE
    );
endinterface

// File: rtl/reset_sequencer.sv
// Three-stage reset sequencer. Each stage is released after a fixed delay and
// must acknowledge within a timeout; the next stage only starts once the
// previous one is acknowledged. A soft restart drains stages in reverse order
// from RUN, aborts an in-progress bring-up, or clears a fault.
module reset_sequencer #(
    parameter int unsigned      DLY_W     = 22,
    parameter logic [DLY_W-1:0] STAGE_DLY = DLY_W'(22'h0FFFFF),
    parameter logic [DLY_W-1:0] ACK_TO    = DLY_W'(22'h00FFFF)
) (
    input  logic             iCLK,
    input  logic             reset_reg_N,
    reset_sequencer_if.slave seqBus
);
    localparam logic [1:0] LAST_STG = 2'd2;

    typedef enum logic [2:0] {
        stWait  = 3'd0,
        stAckw  = 3'd1,
        stRun   = 3'd2,
        stDrain = 3'd3,
        stFault = 3'd4
    } stateT;

    stateT            state;
    logic [DLY_W-1:0] cnt;     // shared release-delay / acknowledge-timeout counter
    logic [1:0]       stg;     // stage currently being brought up or drained
    logic [2:0]       rstQ;    // per-stage release, bit k = stage k out of reset
    logic             doneQ;
    logic             faultQ;

    // Single FSM: state, counter, stage index and all outputs registered together.
    // The counter is compared before incrementing and is cleared on every
    // phase change, so it never wraps.
    always_ff @(posedge iCLK or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            state  <= stWait;
            cnt    <= '0;
            stg    <= '0;
            rstQ   <= '0;
            doneQ  <= 1'b0;
            faultQ <= 1'b0;
        end else begin
            case (state)
                stWait: begin
                    if (seqBus.iRESTART) begin
                        // abort bring-up and start over from stage 0
                        rstQ  <= '0;
                        stg   <= '0;
                        cnt   <= '0;
                        state <= stWait;
                    end else if (cnt == STAGE_DLY) begin
                        rstQ[stg] <= 1'b1;
                        cnt       <= '0;
                        state     <= stAckw;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                stAckw: begin
                    // restart outranks both the acknowledge and the timeout
                    if (seqBus.iRESTART) begin
                        rstQ  <= '0;
                        stg   <= '0;
                        cnt   <= '0;
                        state <= stWait;
                    end else if (seqBus.iACK[stg]) begin
                        cnt <= '0;
                        if (stg == LAST_STG) begin
                            doneQ <= 1'b1;
                            state <= stRun;
                        end else begin
                            stg   <= stg + 2'd1;
                            state <= stWait;
                        end
                    end else if (cnt == ACK_TO) begin
                        rstQ   <= '0;
                        faultQ <= 1'b1;
                        state  <= stFault;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                stRun: begin
                    if (seqBus.iRESTART) begin
                        // last stage drops here; the rest drain one per edge
                        doneQ   <= 1'b0;
                        rstQ[2] <= 1'b0;
                        stg     <= 2'd1;
                        state   <= stDrain;
                    end else if (!(&seqBus.iACK)) begin
                        // a stage lost its ready after bring-up completed
                        rstQ   <= '0;
                        doneQ  <= 1'b0;
                        faultQ <= 1'b1;
                        state  <= stFault;
                    end
                end

                stDrain: begin
                    // restart requests are ignored while draining
                    rstQ[stg] <= 1'b0;
                    if (stg == 2'd0) begin
                        cnt   <= '0;
                        state <= stWait;
                    end else begin
                        stg <= stg - 2'd1;
                    end
                end

                stFault: begin
                    // outputs frozen until software requests a restart
                    if (seqBus.iRESTART) begin
                        faultQ <= 1'b0;
                        stg    <= '0;
                        cnt    <= '0;
                        state  <= stWait;
                    end
                end

                default: begin
                    state  <= stWait;
                    cnt    <= '0;
                    stg    <= '0;
                    rstQ   <= '0;
                    doneQ  <= 1'b0;
                    faultQ <= 1'b0;
                end
            endcase
        end
    end

    assign seqBus.oRST_0 = rstQ[0];
    assign seqBus.oRST_1 = rstQ[1];
    assign seqBus.oRST_2 = rstQ[2];
    assign seqBus.oDONE  = doneQ;
    assign seqBus.oFAULT = faultQ;
    assign seqBus.oSTAGE = stg;
endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer with STAGE_DLY=4, ACK_TO=3: directed edge-by-edge
// scenarios with literal expectations, plus a per-cycle compare against a
// phase/timer model that tracks how many stages are released.
module tb_reset_sequencer;
    localparam int SD = 4;
    localparam int AT = 3;

    logic iCLK = 1'b0;
    logic reset_reg_N = 1'b1;
    reset_sequencer_if bus ();

    reset_sequencer #(
        .DLY_W     (22),
        .STAGE_DLY (22'd4),
        .ACK_TO    (22'd3)
    ) dut (
        .iCLK        (iCLK),
        .reset_reg_N (reset_reg_N),
        .seqBus      (bus)
    );

    always #5 iCLK = ~iCLK;

    int total = 0;
    int bad = 0;
    bit checkOn = 1'b0;

    // Model: phase 0 = delay count, 1 = awaiting ack, 2 = running,
    // 3 = draining, 4 = faulted. mRel = number of released stages.
    int mPhase = 0;
    int mRel = 0;
    int mStage = 0;
    int mTimer = 0;
    bit mDone = 1'b0;
    bit mFault = 1'b0;

    task automatic modelStep(input bit rs, input logic [2:0] ack);
        case (mPhase)
            0: begin
                if (rs) begin mRel = 0; mStage = 0; mTimer = 0; end
                else if (mTimer == SD) begin mRel = mStage + 1; mTimer = 0; mPhase = 1; end
                else mTimer++;
            end
            1: begin
                if (rs) begin mRel = 0; mStage = 0; mTimer = 0; mPhase = 0; end
                else if (ack[mStage]) begin
                    mTimer = 0;
                    if (mStage == 2) begin mDone = 1'b1; mPhase = 2; end
                    else begin mStage++; mPhase = 0; end
                end
                else if (mTimer == AT) begin mRel = 0; mFault = 1'b1; mPhase = 4; end
                else mTimer++;
            end
            2: begin
                if (rs) begin mDone = 1'b0; mRel = 2; mStage = 1; mPhase = 3; end
                else if (ack != 3'b111) begin mRel = 0; mDone = 1'b0; mFault = 1'b1; mPhase = 4; end
            end
            3: begin
                mRel = mStage;
                if (mStage == 0) begin mTimer = 0; mPhase = 0; end
                else mStage--;
            end
            default: begin
                if (rs) begin mFault = 1'b0; mStage = 0; mTimer = 0; mPhase = 0; end
            end
        endcase
    endtask

    always @(posedge iCLK or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            mPhase = 0; mRel = 0; mStage = 0; mTimer = 0; mDone = 1'b0; mFault = 1'b0;
        end else begin
            modelStep(bus.iRESTART, bus.iACK);
        end
    end

    function automatic logic [6:0] expv(input logic [2:0] r, input logic d, input logic f,
                                        input logic [1:0] s);
        return {r, d, f, s};
    endfunction

    function automatic logic [6:0] dutVec();
        return {bus.oRST_2, bus.oRST_1, bus.oRST_0, bus.oDONE, bus.oFAULT, bus.oSTAGE};
    endfunction

    function automatic logic [6:0] modelVec();
        logic [2:0] r;
        r = 3'((1 << mRel) - 1);
        return expv(r, mDone, mFault, 2'(mStage));
    endfunction

    task automatic check(input string name, input logic [6:0] got, input logic [6:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got={rst2,rst1,rst0,done,fault,stg}=%b exp=%b at %0t", name, got, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, plus release ordering on the DUT.
    always @(negedge iCLK) begin
        if (checkOn) begin
            check("model", dutVec(), modelVec());
            total++;
            if ((bus.oRST_2 && !bus.oRST_1) || (bus.oRST_1 && !bus.oRST_0)) begin
                bad++;
                $display("FAIL order got rst=%b%b%b exp thermometer at %0t",
                         bus.oRST_2, bus.oRST_1, bus.oRST_0, $time);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge iCLK);
        #1;
    endtask

    // Bring-up with all acks present, counted from the reset-release edge.
    task automatic nominal(input string tag);
        step(4);  check({tag, "_e4"},  dutVec(), expv(3'b000, 0, 0, 2'd0));
        step(1);  check({tag, "_e5"},  dutVec(), expv(3'b001, 0, 0, 2'd0));
        step(1);  check({tag, "_e6"},  dutVec(), expv(3'b001, 0, 0, 2'd1));
        step(4);  check({tag, "_e10"}, dutVec(), expv(3'b001, 0, 0, 2'd1));
        step(1);  check({tag, "_e11"}, dutVec(), expv(3'b011, 0, 0, 2'd1));
        step(1);  check({tag, "_e12"}, dutVec(), expv(3'b011, 0, 0, 2'd2));
        step(4);  check({tag, "_e16"}, dutVec(), expv(3'b011, 0, 0, 2'd2));
        step(1);  check({tag, "_e17"}, dutVec(), expv(3'b111, 0, 0, 2'd2));
        step(1);  check({tag, "_e18"}, dutVec(), expv(3'b111, 1, 0, 2'd2));
    endtask

    initial begin
        bus.iRESTART = 1'b0;
        bus.iACK = 3'b000;
        #2 reset_reg_N = 1'b0;
        checkOn = 1'b1;
        step(2);
        check("reset_state", dutVec(), expv(3'b000, 0, 0, 2'd0));

        // nominal bring-up
        bus.iACK = 3'b111;
        reset_reg_N = 1'b1;
        nominal("nom");

        // restart from RUN; held through the first drain edge, which ignores it
        bus.iRESTART = 1'b1;
        step(1); check("drain_1", dutVec(), expv(3'b011, 0, 0, 2'd1));
        step(1); check("drain_2", dutVec(), expv(3'b001, 0, 0, 2'd0));
        bus.iRESTART = 1'b0;
        step(1); check("drain_3", dutVec(), expv(3'b000, 0, 0, 2'd0));
        step(4); check("redo_pre", dutVec(), expv(3'b000, 0, 0, 2'd0));
        step(1); check("redo_rst0", dutVec(), expv(3'b001, 0, 0, 2'd0));
        step(13); check("redo_done", dutVec(), expv(3'b111, 1, 0, 2'd2));

        // lost acknowledge in RUN
        bus.iACK = 3'b110;
        step(1); check("lost_ack", dutVec(), expv(3'b000, 0, 1, 2'd2));
        step(2); check("fault_hold", dutVec(), expv(3'b000, 0, 1, 2'd2));
        bus.iACK = 3'b111;
        bus.iRESTART = 1'b1;
        step(1); check("fault_clr", dutVec(), expv(3'b000, 0, 0, 2'd0));
        bus.iRESTART = 1'b0;
        step(4); check("fc_pre", dutVec(), expv(3'b000, 0, 0, 2'd0));
        step(1); check("fc_rst0", dutVec(), expv(3'b001, 0, 0, 2'd0));

        // stage 1 never acknowledges: timeout
        bus.iACK = 3'b101;
        step(6); check("to_rst1", dutVec(), expv(3'b011, 0, 0, 2'd1));
        step(3); check("to_pre", dutVec(), expv(3'b011, 0, 0, 2'd1));
        step(1); check("to_fault", dutVec(), expv(3'b000, 0, 1, 2'd1));
        bus.iRESTART = 1'b1;
        step(1); check("to_clr", dutVec(), expv(3'b000, 0, 0, 2'd0));
        bus.iRESTART = 1'b0;
        bus.iACK = 3'b111;

        // abort in WAIT of stage 1, then abort beating ack in ACKW
        step(6); check("ab_wait1", dutVec(), expv(3'b001, 0, 0, 2'd1));
        bus.iRESTART = 1'b1;
        step(1); check("ab_wait", dutVec(), expv(3'b000, 0, 0, 2'd0));
        bus.iRESTART = 1'b0;
        step(5); check("ab_cnt0", dutVec(), expv(3'b001, 0, 0, 2'd0));
        bus.iRESTART = 1'b1;
        step(1); check("ab_ackw", dutVec(), expv(3'b000, 0, 0, 2'd0));
        bus.iRESTART = 1'b0;

        // asynchronous reset mid-ACKW, then bring-up timing repeats
        step(5); check("ar_ackw", dutVec(), expv(3'b001, 0, 0, 2'd0));
        bus.iACK = 3'b000;
        step(1); check("ar_wait", dutVec(), expv(3'b001, 0, 0, 2'd0));
        #3 reset_reg_N = 1'b0;
        #1 check("ar_async", dutVec(), expv(3'b000, 0, 0, 2'd0));
        step(1); check("ar_held", dutVec(), expv(3'b000, 0, 0, 2'd0));
        bus.iACK = 3'b111;
        reset_reg_N = 1'b1;
        nominal("rep");

        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter DLY_W, default 22: bit width of the shared delay/timeout counter.
REQ-002 Parameter STAGE_DLY, default 22'h0FFFFF: cycles counted before each stage release; range 0..2^DLY_W-1.
REQ-003 Parameter ACK_TO, default 22'h00FFFF: cycles allowed for a stage acknowledge; range 0..2^DLY_W-1.
REQ-004 iCLK  input  1  single clock; all state changes on its rising edge.
REQ-005 reset_reg_N  input  1  asynchronous, active-low reset.
REQ-006 iRESTART  input  1  soft-restart request, sampled each cycle (level; a one-cycle pulse suffices).
REQ-007 iACK  input  3  per-stage ready; bit k belongs to stage k.
REQ-008 oRST_0, oRST_1, oRST_2  output  1 each  stage release; 1 = stage out of reset.
REQ-009 oDONE  output  1  all three stages released and acknowledged.
REQ-010 oFAULT  output  1  acknowledge timeout or lost acknowledge.
REQ-011 oSTAGE  output  2  current stage index (0..2).

Function
REQ-012 States: WAIT, ACKW, RUN, DRAIN, FAULT; counter cnt[DLY_W-1:0]; stage index stg = oSTAGE.
REQ-013 WAIT: cnt==STAGE_DLY -> oRST_stg<=1, cnt<=0, ACKW; else cnt<=cnt+1.
REQ-014 ACKW: iACK[stg]==1 -> cnt<=0; stg<2: stg<=stg+1, WAIT; stg==2: oDONE<=1, RUN.
REQ-015 ACKW, iACK[stg]==0, cnt==ACK_TO -> all oRST<=0, oFAULT<=1, FAULT; else cnt<=cnt+1.
REQ-016 cnt compared before increment; it never wraps; STAGE_DLY=0 releases on the first WAIT edge; ACK_TO=0 faults unless the acknowledge is present on the first ACKW edge.
REQ-017 RUN: iRESTART==1 -> oDONE<=0, oRST_2<=0, stg<=1, DRAIN.
REQ-018 RUN with iRESTART==0 and any iACK bit 0 -> all oRST<=0, oDONE<=0, oFAULT<=1, FAULT.
REQ-019 DRAIN: one edge per stage in reverse order: clear oRST_stg, then stg<=stg-1; after clearing oRST_0: stg<=0, cnt<=0, WAIT.
REQ-020 iRESTART in WAIT or ACKW: all oRST<=0, stg<=0, cnt<=0, WAIT (abort); restart has priority over acknowledge and timeout in the same cycle.
REQ-021 iRESTART during DRAIN is ignored.
REQ-022 FAULT: outputs held; iRESTART -> oFAULT<=0, stg<=0, cnt<=0, WAIT.
REQ-023 oRST_k=1 implies oRST_j=1 for all j<k at every cycle boundary.

Reset
REQ-024 reset_reg_N low asynchronously forces oRST_0..2=0, oDONE=0, oFAULT=0, oSTAGE=0, cnt=0, state WAIT, from any state.
REQ-025 Sequencing starts on the first rising iCLK edge after reset_reg_N rises (edge 1).

Verification (STAGE_DLY=4, ACK_TO=3)
REQ-026 iACK=3'b111, release reset -> oRST_0 rises at edge 5, oRST_1 at edge 11, oRST_2 at edge 17, oDONE at edge 18, oSTAGE 0->1 at edge 6 and 1->2 at edge 12.
REQ-027 iACK=3'b101 -> oRST_1 rises at edge 11; at edge 15 oFAULT=1 and oRST_0=oRST_1=0; iRESTART pulse then clears oFAULT and restarts from stage 0.
REQ-028 In RUN, one-cycle iRESTART -> next edge oDONE=0 and oRST_2=0; following edge oRST_1=0; following edge oRST_0=0; oRST_0 rises again 5 edges later.
REQ-029 iRESTART asserted in WAIT of stage 1 with oRST_0=1 -> next edge oRST_0=0, oSTAGE=0, cnt=0; with iRESTART and iACK[stg] both high in ACKW -> abort wins.
REQ-030 In RUN, drop iACK[0] -> next edge oFAULT=1, oDONE=0, all oRST=0.
REQ-031 Pull reset_reg_N low mid-ACKW, between clock edges -> all outputs 0 immediately; release -> REQ-026 timing repeats exactly.
